phase_detector_multi_fifo: RTL and testbench

PHASE_DETECTOR_MULTI_FIFO -- requirements
Module: phase_detector_multi_fifo

---
 rtl/phase_detector_multi_fifo.sv | 226 ++++++++++++++++++++++
 tb/tb_phase_detector_multi_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_detector_multi_fifo.sv
// Multi-channel phase detector: each clk_in edge is timed against the preceding clk_ref edge and
// the resulting {ch, ref_cnt, phase} tag is queued in a FWFT FIFO. Optional macro: PD_ALMOST_EMPTY_EN.
module phase_detector_multi_fifo #(
    parameter int NUM_CH          = 4,
    parameter int PHASE_W         = 5,
    parameter int REF_CNT_W       = 3,
    parameter int FIFO_DEPTH      = 16,
    parameter int ALMOST_EMPTY_TH = 2,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int TAG_W = CH_W + REF_CNT_W + PHASE_W,
    localparam int AW    = $clog2(FIFO_DEPTH)
) (
    input  logic              clk_sample,
    input  logic              rst,
    input  logic              clk_ref,
    input  logic [NUM_CH-1:0] clk_in,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              rd_en,
    input  logic              clr_overflow,
    output logic [TAG_W-1:0]  data_out,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic [AW:0]       level,
    output logic              overflow
);

    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [PHASE_W-1:0] PH_MAX = '1;

    logic [NUM_CH:0]          sync_p0, sync_p1, sync_p2;
    logic [NUM_CH:0]          pulse;
    logic                     ref_pulse;
    logic [NUM_CH-1:0]        ch_pulse;
    logic [REF_CNT_W-1:0]     ref_cnt;
    logic [NUM_CH-1:0]        cap_v;
    logic [TAG_W-1:0]         cap_tag [NUM_CH];
    logic [NUM_CH-1:0]        hold_vld;
    logic [TAG_W-1:0]         hold_tag [NUM_CH];
    logic [NUM_CH-1:0]        grant;
    logic [NUM_CH-1:0]        drop;
    logic [CH_W-1:0]          grant_idx;
    logic [CH_W-1:0]          rr_ptr;
    logic                     wr_en;
    logic [TAG_W-1:0]         wr_data;
    logic                     rd_acc;
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [AW:0]              level_nxt;
    logic [TAG_W-1:0]         mem [FIFO_DEPTH];

    // Stage boundary: two-flop synchroniser plus edge-detect register; MSB carries clk_ref.
    always_ff @(posedge clk_sample or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
        end else begin
            sync_p0 <= {clk_ref, clk_in};
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign pulse     = sync_p1 & ~sync_p2;
    assign ref_pulse = pulse[NUM_CH];
    assign ch_pulse  = pulse[NUM_CH-1:0];

    always_ff @(posedge clk_sample or negedge rst) begin
        if (!rst)           ref_cnt <= '0;
        else if (ref_pulse) ref_cnt <= ref_cnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t               state, state_nxt;
        logic [PHASE_W-1:0]   cnt, cnt_nxt;
        logic [REF_CNT_W-1:0] start_ref, start_ref_nxt;
        logic                 cap;
        logic [PHASE_W-1:0]   cap_phase;
        logic [REF_CNT_W-1:0] cap_ref;

        always_ff @(posedge clk_sample or negedge rst) begin
            if (!rst) begin
                state     <= IDLE;
                cnt       <= '0;
                start_ref <= '0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                start_ref <= start_ref_nxt;
            end
        end

        // The ref-edge cycle is phase 0, so the counter already holds 1 in the first COUNT cycle.
        always_comb begin
            state_nxt     = state;
            cnt_nxt       = cnt;
            start_ref_nxt = start_ref;
            cap           = 1'b0;
            cap_phase     = cnt;
            cap_ref       = start_ref;
            case (state)
                IDLE: begin
                    if (ref_pulse && ch_enable[i]) begin
                        if (ch_pulse[i]) begin
                            cap       = 1'b1;
                            cap_phase = '0;
                            cap_ref   = ref_cnt;
                        end else begin
                            state_nxt     = COUNT;
                            cnt_nxt       = PHASE_W'(1);
                            start_ref_nxt = ref_cnt;
                        end
                    end
                end
                COUNT: begin
                    if (!ch_enable[i]) begin
                        state_nxt = IDLE;
                    end else if (ch_pulse[i]) begin
                        cap       = 1'b1;
                        state_nxt = IDLE;
                    end else if (ref_pulse) begin
                        cnt_nxt       = PHASE_W'(1);
                        start_ref_nxt = ref_cnt;
                    end else if (cnt == PH_MAX) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        assign cap_v[i]   = cap;
        assign cap_tag[i] = {CH_W'(i), cap_ref, cap_phase};
    end

    // Round-robin search begins one past the channel granted last.
    always_comb begin
        int idx;
        logic found;
        idx       = 0;
        found     = 1'b0;
        grant     = '0;
        grant_idx = rr_ptr;
        wr_data   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && !full && hold_vld[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = CH_W'(idx);
                wr_data    = hold_tag[idx];
            end
        end
    end

    assign wr_en = |grant;
    assign drop  = cap_v & hold_vld & ~grant;

    always_ff @(posedge clk_sample or negedge rst) begin
        if (!rst) begin
            hold_vld <= '0;
            rr_ptr   <= CH_W'(NUM_CH - 1);
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cap_v[i] && (!hold_vld[i] || grant[i])) hold_vld[i] <= 1'b1;
                else if (grant[i])                          hold_vld[i] <= 1'b0;
            end
            if (wr_en) rr_ptr <= grant_idx;
        end
    end

    always_ff @(posedge clk_sample) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (cap_v[i] && (!hold_vld[i] || grant[i])) hold_tag[i] <= cap_tag[i];
        end
    end

    // Stage boundary: tag FIFO write/read.
    assign rd_acc = rd_en && !empty;

    always_comb begin
        level_nxt = level;
        if (wr_en && !rd_acc)      level_nxt = level + 1'b1;
        else if (!wr_en && rd_acc) level_nxt = level - 1'b1;
    end

    always_ff @(posedge clk_sample) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk_sample or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
        end
    end

    assign empty    = (level == '0);
    assign full     = (level == (AW+1)'(FIFO_DEPTH));
    assign data_out = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_sample or negedge rst) begin
        if (!rst)              overflow <= 1'b0;
        else if (|drop)        overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end

`ifdef PD_ALMOST_EMPTY_EN
    always_ff @(posedge clk_sample or negedge rst) begin
        if (!rst) almost_empty <= 1'b1;
        else      almost_empty <= (int'(level_nxt) <= ALMOST_EMPTY_TH);
    end
`else
    assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_phase_detector_multi_fifo.sv
// Scoreboard bench for phase_detector_multi_fifo: stimulus queues expected tags, a monitor pops on reads.
module tb_phase_detector_multi_fifo;
    localparam int TAG_W = 10;

`ifdef PD_ALMOST_EMPTY_EN
    localparam logic AE_EN = 1'b1;
`else
    localparam logic AE_EN = 1'b0;
`endif

    logic             clk_sample = 1'b0;
    logic             rst = 1'b1;
    logic             clk_ref = 1'b0;
    logic [3:0]       clk_in = '0;
    logic [3:0]       ch_enable = '0;
    logic             rd_en = 1'b0;
    logic             clr_overflow = 1'b0;
    logic [TAG_W-1:0] data_out;
    logic             empty, full, almost_empty, overflow;
    logic [4:0]       level;

    int total = 0;
    int bad   = 0;
    logic [TAG_W-1:0] exp_q [$];

    phase_detector_multi_fifo dut (
        .clk_sample   (clk_sample),
        .rst          (rst),
        .clk_ref      (clk_ref),
        .clk_in       (clk_in),
        .ch_enable    (ch_enable),
        .rd_en        (rd_en),
        .clr_overflow (clr_overflow),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow)
    );

    always #5 clk_sample = ~clk_sample;

    function automatic logic [TAG_W-1:0] mk_tag(input int ch, input int rc, input int ph);
        logic [1:0] c;
        logic [2:0] r;
        logic [4:0] p;
        c = ch[1:0];
        r = rc[2:0];
        p = ph[4:0];
        return {c, r, p};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_sample);
            #1;
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk_sample);
            if (rst && rd_en && !empty) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got %0h expected no tag", data_out);
                end else begin
                    check("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
        end
    endtask

    task automatic hard_reset();
        check("queue_drained", exp_q.size(), 0);
        rst = 1'b0;
        clk_ref = 1'b0;
        clk_in = '0;
        rd_en = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
    endtask

    initial begin
        fork
            monitor();
            begin
                int w;
                // reset state
                #2 rst = 1'b0;
                #2;
                check("rst_empty", empty, 1);
                check("rst_full", full, 0);
                check("rst_level", level, 0);
                check("rst_overflow", overflow, 0);
                check("rst_data", data_out, 0);
                check("rst_almost_empty", almost_empty, AE_EN);
                tick(2);
                rst = 1'b1;
                tick(2);

                // ch1 edge 7 cycles after ref, 40-cycle period, ref_cnt 0..7 then wrap
                ch_enable = 4'b0010;
                rd_en = 1'b1;
                for (int p = 0; p < 9; p++) begin
                    exp_q.push_back(mk_tag(1, p % 8, 7));
                    clk_ref = 1'b1; tick(7);
                    clk_in[1] = 1'b1; tick(13);
                    clk_ref = 1'b0; tick(7);
                    clk_in[1] = 1'b0; tick(13);
                end
                tick(5);
                check("t2_queue_empty", exp_q.size(), 0);
                check("t2_overflow", overflow, 0);

                // all channels at once: four consecutive writes in order 0..3
                hard_reset();
                ch_enable = 4'hF;
                for (int c = 0; c < 4; c++) exp_q.push_back(mk_tag(c, 0, 5));
                clk_ref = 1'b1; tick(5);
                clk_in = 4'hF;
                w = 0;
                while (empty === 1'b1 && w < 20) begin
                    tick();
                    w++;
                end
                check("t3_nonempty", empty, 0);
                check("t3_level1", level, 1); tick();
                check("t3_level2", level, 2); tick();
                check("t3_level3", level, 3); tick();
                check("t3_level4", level, 4); tick(3);
                check("t3_level_hold", level, 4);
                check("t3_overflow", overflow, 0);
                rd_en = 1'b1; tick(7);
                check("t3_queue_empty", exp_q.size(), 0);
                check("t3_empty_after_extra_rd", empty, 1);
                check("t3_level_after_extra_rd", level, 0);
                rd_en = 1'b0;
                clk_ref = 1'b0; clk_in = '0; tick(3);

                // fill to 16, then held, then dropped
                hard_reset();
                ch_enable = 4'hF;
                for (int p = 0; p < 6; p++) begin
                    if (p < 5) for (int c = 0; c < 4; c++) exp_q.push_back(mk_tag(c, p, 3));
                    clk_ref = 1'b1; tick(3);
                    clk_in = 4'hF; tick(7);
                    clk_ref = 1'b0; tick(3);
                    clk_in = '0; tick(7);
                end
                check("t4_full", full, 1);
                check("t4_level16", level, 16);
                check("t4_overflow", overflow, 1);
                clr_overflow = 1'b1; tick();
                clr_overflow = 1'b0;
                check("t4_overflow_cleared", overflow, 0);
                rd_en = 1'b1; tick();
                rd_en = 1'b0;
                check("t4_level_after_pop", level, 15);
                check("t4_not_full", full, 0);
                tick();
                check("t4_held_written", level, 16);
                check("t4_full_again", full, 1);
                rd_en = 1'b1; tick(24);
                rd_en = 1'b0;
                check("t4_queue_empty", exp_q.size(), 0);
                check("t4_empty", empty, 1);

                // ch0 timeout, 31-cycle boundary, phase 0, ref restart
                hard_reset();
                ch_enable = 4'b0001;
                rd_en = 1'b1;
                clk_ref = 1'b1; tick(40);
                clk_in[0] = 1'b1; tick(8);
                check("t5_timeout_no_tag", level, 0);
                clk_ref = 1'b0; clk_in = '0; tick(4);
                exp_q.push_back(mk_tag(0, 1, 31));
                clk_ref = 1'b1; tick(31);
                clk_in[0] = 1'b1; tick(8);
                clk_ref = 1'b0; clk_in = '0; tick(4);
                check("t5_phase31_seen", exp_q.size(), 0);
                clk_ref = 1'b1; tick(32);
                clk_in[0] = 1'b1; tick(8);
                check("t5_phase32_no_tag", level, 0);
                clk_ref = 1'b0; clk_in = '0; tick(4);
                exp_q.push_back(mk_tag(0, 3, 0));
                clk_ref = 1'b1; clk_in[0] = 1'b1; tick(8);
                clk_ref = 1'b0; clk_in = '0; tick(4);
                check("t5_phase0_seen", exp_q.size(), 0);
                clk_ref = 1'b1; tick(5);
                clk_ref = 1'b0; tick(10);
                exp_q.push_back(mk_tag(0, 5, 6));
                clk_ref = 1'b1; tick(6);
                clk_in[0] = 1'b1; tick(8);
                clk_ref = 1'b0; clk_in = '0; tick(4);
                check("t5_restart_seen", exp_q.size(), 0);
                rd_en = 1'b0;

                // reset mid-COUNT with three tags queued
                hard_reset();
                ch_enable = 4'b0111;
                clk_ref = 1'b1; tick(4);
                clk_in = 4'b0111; tick(8);
                check("t6_level3", level, 3);
                clk_ref = 1'b0; clk_in = '0; tick(5);
                clk_ref = 1'b1; tick(6);
                #3;
                rst = 1'b0;
                clk_ref = 1'b0;
                #1;
                check("t6_rst_empty", empty, 1);
                check("t6_rst_level", level, 0);
                check("t6_rst_full", full, 0);
                check("t6_rst_data", data_out, 0);
                tick(2);
                rst = 1'b1;
                tick(2);
                clk_in = 4'b0111; tick(10);
                check("t6_no_stale_tag", level, 0);
                check("t6_still_empty", empty, 1);

                // almost_empty around the threshold
                hard_reset();
                ch_enable = 4'b0111;
                for (int c = 0; c < 3; c++) exp_q.push_back(mk_tag(c, 0, 4));
                clk_ref = 1'b1; tick(4);
                clk_in = 4'b0111; tick(8);
                check("t7_level3", level, 3);
                check("t7_ae_level3", almost_empty, 0);
                rd_en = 1'b1; tick();
                rd_en = 1'b0;
                check("t7_level2", level, 2);
                check("t7_ae_level2", almost_empty, AE_EN);
                rd_en = 1'b1; tick(4);
                rd_en = 1'b0;
                check("t7_queue_empty", exp_q.size(), 0);
                check("t7_ae_level0", almost_empty, AE_EN);

                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join
    end

endmodule
